// File: rtl/voting_pkg.sv
// ============================================================================
// voting_pkg : shared state encoding and sizing helpers for the voting tally.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package voting_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SCAN    = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic int unsigned pow2(input int unsigned w);
        return 32'd1 << w;
    endfunction

    // A tally must hold every ballot of the election going to one candidate.
    function automatic int unsigned tally_width(input int unsigned m);
        return m + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/voting_tally_bank.sv
// ============================================================================
// voting_tally_bank : 2**N per-candidate counters with clear, increment by
//                     index and combinational read by index.
// Revision          : 1.0 - initial release
// ============================================================================
`default_nettype none

module voting_tally_bank
    import voting_pkg::*;
#(
    parameter int N  = 3,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          inc,
    input  logic [N-1:0]  inc_idx,
    input  logic [N-1:0]  rd_idx,
    output logic [CW-1:0] rd_cnt
);

    localparam int NCAND = pow2(N);

    logic [CW-1:0] tally [NCAND];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCAND; i++) begin
                tally[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < NCAND; i++) begin
                tally[i] <= '0;
            end
        end else if (inc) begin
            tally[inc_idx] <= tally[inc_idx] + 1'b1;
        end
    end

    assign rd_cnt = tally[rd_idx];

endmodule

`default_nettype wire

// File: rtl/voting_seq_tally.sv
// ============================================================================
// voting_seq_tally : streaming plurality voter - collects 2**M ballots over a
//                    valid/ready handshake, then scans 2**N tallies for the
//                    winner. Optional tie output via VOTING_TIE_FLAG_EN.
// Revision         : 1.0 - initial release
// ============================================================================
`default_nettype none

module voting_seq_tally
    import voting_pkg::*;
#(
    parameter int N = 3,
    parameter int M = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         vote_valid,
    output logic         vote_ready,
    input  logic [N-1:0] vote,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] winner,
    output logic [M:0]   winner_count
`ifdef VOTING_TIE_FLAG_EN
    ,
    output logic         tie
`endif
);

    localparam int            CW          = tally_width(M);
    localparam int            NBAL        = pow2(M);
    localparam logic [CW-1:0] LAST_BALLOT = CW'(NBAL - 1);
    localparam logic [N-1:0]  LAST_IDX    = '1;

    state_t        state;
    logic [CW-1:0] ballot_cnt;
    logic [N-1:0]  idx;
    logic [N-1:0]  best_idx;
    logic [CW-1:0] best_cnt;
    logic [CW-1:0] rd_cnt;
    logic          accept;
    logic          start_ok;

    assign accept   = vote_valid & vote_ready;
    assign start_ok = start & ((state == IDLE) | (state == DONE));

    voting_tally_bank #(
        .N  (N),
        .CW (CW)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start_ok),
        .inc     (accept),
        .inc_idx (vote),
        .rd_idx  (idx),
        .rd_cnt  (rd_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            vote_ready   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            winner       <= '0;
            winner_count <= '0;
            ballot_cnt   <= '0;
            idx          <= '0;
            best_idx     <= '0;
            best_cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= COLLECT;
                        vote_ready   <= 1'b1;
                        busy         <= 1'b1;
                        ballot_cnt   <= '0;
                        best_idx     <= '0;
                        best_cnt     <= '0;
                        winner       <= '0;
                        winner_count <= '0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        ballot_cnt <= ballot_cnt + 1'b1;
                        if (ballot_cnt == LAST_BALLOT) begin
                            state      <= SCAN;
                            vote_ready <= 1'b0;
                            idx        <= '0;
                        end
                    end
                end
                SCAN: begin
                    // Strict compare keeps the lowest index on ties.
                    if (rd_cnt > best_cnt) begin
                        best_idx <= idx;
                        best_cnt <= rd_cnt;
                    end
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    done         <= 1'b1;
                    winner       <= best_idx;
                    winner_count <= best_cnt;
                    if (start) begin
                        state      <= COLLECT;
                        vote_ready <= 1'b1;
                        busy       <= 1'b1;
                        ballot_cnt <= '0;
                        best_idx   <= '0;
                        best_cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VOTING_TIE_FLAG_EN
    logic best_tie;

    // A later candidate matching a non-zero best means the maximum is shared;
    // a strictly greater one supersedes any earlier tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_tie <= 1'b0;
            tie      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        best_tie <= 1'b0;
                        tie      <= 1'b0;
                    end
                end
                SCAN: begin
                    if (rd_cnt > best_cnt) begin
                        best_tie <= 1'b0;
                    end else if ((rd_cnt == best_cnt) && (best_cnt != '0)) begin
                        best_tie <= 1'b1;
                    end
                end
                DONE: begin
                    tie <= best_tie;
                    if (start) begin
                        best_tie <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_voting_seq_tally.sv
// ============================================================================
// tb_voting_seq_tally : directed bench for voting_seq_tally with a histogram
//                       reference model and per-cycle output comparison.
// Revision            : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_voting_seq_tally;

    typedef logic [2:0] ballots_t [8];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       vote_valid = 1'b0;
    logic [2:0] vote = '0;
    logic       vote_ready;
    logic       busy;
    logic       done;
    logic [2:0] winner;
    logic [3:0] winner_count;
`ifdef VOTING_TIE_FLAG_EN
    logic       tie;
`endif

    voting_seq_tally #(.N(3), .M(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .vote_valid   (vote_valid),
        .vote_ready   (vote_ready),
        .vote         (vote),
        .busy         (busy),
        .done         (done),
        .winner       (winner),
        .winner_count (winner_count)
`ifdef VOTING_TIE_FLAG_EN
        ,
        .tie          (tie)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: histogram of accepted ballots plus cycle countdown to done.
    int m_cnt [8];
    int m_n;
    bit m_collect;
    int m_cd;
    bit can_start;
    bit hs;
    bit exp_ready, exp_busy, exp_done;
    int exp_win, exp_wc;
    bit exp_tie;

    function automatic void compute_result();
        int best_v = -1;
        int n_max  = 0;
        for (int c = 0; c < 8; c++) begin
            if (m_cnt[c] > best_v) begin
                best_v  = m_cnt[c];
                exp_win = c;
            end
        end
        for (int c = 0; c < 8; c++) begin
            if (m_cnt[c] == best_v) n_max++;
        end
        exp_wc  = best_v;
        exp_tie = (n_max >= 2);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 8; c++) m_cnt[c] = 0;
            m_n = 0; m_collect = 0; m_cd = 0;
            exp_ready = 0; exp_busy = 0; exp_done = 0;
            exp_win = 0; exp_wc = 0; exp_tie = 0;
        end else begin
            can_start = (!m_collect && m_cd == 0) || (m_cd == 1);
            hs        = vote_valid && exp_ready;
            exp_done  = 0;
            if (m_collect) begin
                if (hs) begin
                    m_cnt[vote]++;
                    m_n++;
                    if (m_n == 8) begin
                        m_collect = 0;
                        m_cd      = 9;
                    end
                end
            end else if (m_cd > 0) begin
                m_cd--;
                if (m_cd == 0) begin
                    exp_done = 1;
                    compute_result();
                end
            end
            if (start && can_start) begin
                m_collect = 1;
                m_n       = 0;
                for (int c = 0; c < 8; c++) m_cnt[c] = 0;
            end
            exp_ready = m_collect;
            exp_busy  = m_collect || (m_cd >= 2);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("vote_ready", vote_ready, exp_ready);
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            if (exp_done) begin
                check("winner", winner, exp_win);
                check("winner_count", winner_count, exp_wc);
`ifdef VOTING_TIE_FLAG_EN
                check("tie", tie, exp_tie);
`endif
            end
        end
    end

    ballots_t bl;
    int       lat;

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input ballots_t b, input bit alt, input bit poke);
        for (int i = 0; i < 8; i++) begin
            if (alt) begin
                vote_valid = 1'b0;
                vote       = 3'($urandom_range(0, 7));
                @(negedge clk);
            end
            vote_valid = 1'b1;
            vote       = b[i];
            start      = poke && (i == 3);
            @(negedge clk);
            start = 1'b0;
        end
        vote_valid = 1'b0;
    endtask

    // Negedges counted from the return of feed() until done is seen; -1 on timeout.
    task automatic wait_done(output int k);
        k = -1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (done) begin
                k = j;
                break;
            end
        end
    endtask

    task automatic expect_result(input string tag, input int w, input int wc, input bit t);
        check({tag, "_done_seen"}, (lat > 0), 1);
        check({tag, "_winner"}, winner, w);
        check({tag, "_count"}, winner_count, wc);
`ifdef VOTING_TIE_FLAG_EN
        check({tag, "_tie"}, tie, t);
`else
        if (t) begin end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", vote_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_winner", winner, 0);
        check("rst_count", winner_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 6,6,1,1,7,7,7,2: done 9 cycles after the last accepting edge
        bl = '{3'd6, 3'd6, 3'd1, 3'd1, 3'd7, 3'd7, 3'd7, 3'd2};
        do_start();
        feed(bl, 1'b0, 1'b0);
        wait_done(lat);
        check("t1_latency", lat, 9);
        expect_result("t1", 7, 3, 1'b0);

        bl = '{3'd7, 3'd7, 3'd1, 3'd4, 3'd4, 3'd4, 3'd4, 3'd2};
        do_start();
        feed(bl, 1'b1, 1'b0);
        wait_done(lat);
        expect_result("t2", 4, 4, 1'b0);

        bl = '{3'd6, 3'd0, 3'd1, 3'd7, 3'd4, 3'd3, 3'd2, 3'd2};
        do_start();
        feed(bl, 1'b0, 1'b0);
        wait_done(lat);
        expect_result("t3", 2, 2, 1'b0);

        bl = '{3'd6, 3'd6, 3'd1, 3'd4, 3'd5, 3'd3, 3'd5, 3'd7};
        do_start();
        feed(bl, 1'b0, 1'b0);
        wait_done(lat);
        expect_result("t4", 5, 2, 1'b1);

        // start pulsed mid-collect must be ignored
        bl = '{3'd3, 3'd3, 3'd3, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        do_start();
        feed(bl, 1'b0, 1'b1);
        wait_done(lat);
        expect_result("t5", 3, 3, 1'b0);

        // reset in the middle of a scan aborts and clears the held result
        bl = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
        do_start();
        feed(bl, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_winner", winner, 0);
        check("abort_count", winner_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        bl = '{3'd6, 3'd7, 3'd1, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
        do_start();
        feed(bl, 1'b0, 1'b0);
        // eighth negedge after feed returns falls in the DONE-state cycle
        repeat (8) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        check("t6_done_pulse", done, 1);
        check("t6_ready_next", vote_ready, 1);
        expect_result("t6", 7, 6, 1'b0);

        // cleared tallies: the previous six votes for 7 must not carry over
        bl = '{3'd0, 3'd0, 3'd0, 3'd3, 3'd3, 3'd5, 3'd5, 3'd5};
        feed(bl, 1'b0, 1'b0);
        wait_done(lat);
        expect_result("t7", 0, 3, 1'b1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
